approx_add_rr_sched: RTL and testbench
======================================

// Module: approx_add_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one WIDTH-bit ripple-carry adder between N_REQ requesters.
//  The adder's low APPROX_BITS cells are approximate (cell 175_58); the upper cells are exact full adders.
//  Each result is registered once and compared against the exact sum; mismatches are counted for error monitoring.
//  Sits between the requester ports and the response bus on the approximate-arithmetic test datapath.
// PARAMETERS
//  N_REQ        4   number of requesters (>=2)
//  WIDTH        8   operand width; sum width is WIDTH+1
//  APPROX_BITS  2   count of LSB cells using the approximate cell (0..WIDTH)
//  ERR_W        16  width of the saturating mismatch counter
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  approx_en  in   1              1: low cells approximate; 0: all cells exact
//  req_valid  in   N_REQ          per-requester operand valid
//  req_ready  out  N_REQ          per-requester accept (one-hot or zero)
//  req_in1    in   N_REQ*WIDTH    operand A; requester i at [i*WIDTH +: WIDTH]
//  req_in2    in   N_REQ*WIDTH    operand B, same packing
//  rsp_valid  out  1              response holds a result
//  rsp_ready  in   1              consumer accepts the response
//  rsp_id     out  clog2(N_REQ)   index of the requester that produced rsp_sum
//  rsp_sum    out  WIDTH+1        adder result (approximate when approx_en=1)
//  rsp_exact  out  WIDTH+1        exact IN1+IN2 for the same operands
//  rsp_err    out  1              rsp_sum != rsp_exact
//  err_cnt    out  ERR_W          saturating count of mismatched responses delivered
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_exact=0, rsp_err=0, err_cnt=0.
//  - Reset also sets the RR pointer to 0 and discards any held result. Reset mid-transfer loses it with no response.
//  - Approximate cell (carry-in Z): Cout = X | ~Z;  S = (~X & Y) | (X & ~Z).
//  - Cell 0 carry-in is 0. Cell WIDTH-1 carry-out is sum[WIDTH].
//  - The adder and arbitration are combinational; req_ready is a combinational output.
//  - Single state bit FULL (output register occupied); rsp_valid = FULL.
//    - can_accept = !FULL | rsp_ready.
//    - If can_accept and any req_valid: grant the first valid requester at or after ptr (cyclic).
//    - req_ready is asserted only for the granted requester.
//  - On a grant at cycle t:
//    - Operands go through the shared adder; rsp_* is loaded at the edge ending cycle t.
//    - rsp_valid=1 in cycle t+1; ptr <= grant+1 mod N_REQ.
//  - Latency: 1 cycle from accept to rsp_valid. Throughput: 1 result/cycle when rsp_ready is held 1.
//  - Back-pressure: while rsp_valid & !rsp_ready, all rsp_* stay stable and req_ready=0.
//  - Response handshake fires on rsp_valid & rsp_ready:
//    - If a grant occurs in the same cycle, the register is reloaded (FULL stays 1).
//    - Otherwise FULL <= 0.
//  - err_cnt increments on each fired response with rsp_err=1 and saturates at all-ones (no wrap).
//  - approx_en is sampled at grant. Changing it never alters a held result.
//  - No req_valid: ptr holds and no state changes.
//  - ptr wraps N_REQ-1 -> 0.
//  - APPROX_BITS=0 or approx_en=0: rsp_err is always 0.
// STRUCTURE
//  - Shared package approx_add_pkg:
//    - cell-ID localparam (175_58);
//    - default WIDTH/APPROX_BITS;
//    - function clog2;
//    - sum_t typedef [WIDTH:0].
//  - Sub-module rc_approx_adder #(WIDTH, APPROX_BITS)(IN1, IN2, approx_en, Out):
//    - generate-built chain of approximate and exact cells;
//    - one instance only, shared by all requesters.
//  - The exact sum is a plain '+' in this block. Arbiter and counters are local.
// TESTING
//  1. Reset then idle, all req_valid=0 for 10 cycles -> all outputs 0, err_cnt=0.
//  2. Req0 alone, approx_en=1, IN1=0x03, IN2=0x00 -> next cycle:
//     rsp_valid=1, rsp_id=0, rsp_sum=0x005, rsp_exact=0x003, rsp_err=1; err_cnt=1 after accept.
//  3. Req1, approx_en=1, IN1=0xFF, IN2=0x01 -> rsp_sum=0x101, rsp_exact=0x100, rsp_err=1.
//     Repeat with approx_en=0 -> rsp_sum=0x100, rsp_err=0.
//  4. All 4 requesters valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one result/cycle, ids in order.
//  5. rsp_ready=0 for 5 cycles with all requesters valid -> rsp_* frozen, req_ready=0.
//     Release -> next grant goes to the requester after the held id.
//  6. Force err_cnt to 0xFFFE, deliver 3 mismatches -> err_cnt reads 0xFFFF.
//     Assert rst mid-response -> rsp_valid=0 next cycle, ptr=0.

Source files
------------

// File: rtl/approx_add_pkg.sv
// Shared definitions for the approximate-adder scheduler: cell identifiers,
// default geometry and a constant-evaluable clog2.
package approx_add_pkg;

    localparam int CELL_EXACT      = 0;
    localparam int CELL_175_58     = 17558;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_BITS = 2;

    typedef logic [DEF_WIDTH:0] sum_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rc_approx_adder.sv
// Ripple-carry adder whose low APPROX_BITS cells use the 175_58 approximate
// cell when i_approx_en is high; all other cells are exact full adders.
module rc_approx_adder
    import approx_add_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int APPROX_CELL = CELL_175_58
) (
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic             i_approx_en,
    output logic [WIDTH:0]   o_out
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;

    assign w_c[0] = 1'b0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        logic w_x, w_y, w_z;
        assign w_x = i_in1[k];
        assign w_y = i_in2[k];
        assign w_z = w_c[k];
        if (k < APPROX_BITS && APPROX_CELL == CELL_175_58) begin : g_apx
            // Approximate cell: carry-out ignores Y entirely.
            assign w_s[k]   = i_approx_en ? ((~w_x & w_y) | (w_x & ~w_z)) : (w_x ^ w_y ^ w_z);
            assign w_c[k+1] = i_approx_en ? (w_x | ~w_z)
                                          : ((w_x & w_y) | (w_z & (w_x ^ w_y)));
        end else begin : g_exa
            assign w_s[k]   = w_x ^ w_y ^ w_z;
            assign w_c[k+1] = (w_x & w_y) | (w_z & (w_x ^ w_y));
        end
    end

    assign o_out = {w_c[WIDTH], w_s};

endmodule

// File: rtl/approx_add_rr_sched.sv
// Round-robin scheduler sharing one approximate adder between N_REQ requesters,
// with a single-entry registered response and a saturating mismatch counter.
module approx_add_rr_sched
    import approx_add_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int ERR_W       = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_approx_en,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*WIDTH-1:0]    i_req_in1,
    input  logic [N_REQ*WIDTH-1:0]    i_req_in2,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [clog2(N_REQ)-1:0]   o_rsp_id,
    output logic [WIDTH:0]            o_rsp_sum,
    output logic [WIDTH:0]            o_rsp_exact,
    output logic                      o_rsp_err,
    output logic [ERR_W-1:0]          o_err_cnt
);

    localparam int ID_W = clog2(N_REQ);

    logic              r_full;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [WIDTH:0]    r_sum;
    logic [WIDTH:0]    r_exact;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_can_accept;
    logic              w_grant_vld;
    logic              w_accept;
    logic              w_fire;
    logic [ID_W-1:0]   w_grant;
    logic [N_REQ-1:0]  w_ready;
    logic [WIDTH-1:0]  w_in1;
    logic [WIDTH-1:0]  w_in2;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_exact;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // Scan from the far end back toward ptr so the last hit is the nearest valid requester.
    always_comb begin
        w_can_accept = !i_rst && (!r_full || i_rsp_ready);
        w_grant_vld  = 1'b0;
        w_grant      = '0;
        w_ready      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[wrap_add(r_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant     = wrap_add(r_ptr, k);
            end
        end
        w_accept = w_can_accept && w_grant_vld;
        if (w_accept) w_ready[w_grant] = 1'b1;
    end

    always_comb begin
        w_in1 = '0;
        w_in2 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant == ID_W'(k)) begin
                w_in1 = i_req_in1[k*WIDTH +: WIDTH];
                w_in2 = i_req_in2[k*WIDTH +: WIDTH];
            end
        end
    end

    rc_approx_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_adder (
        .i_in1       (w_in1),
        .i_in2       (w_in2),
        .i_approx_en (i_approx_en),
        .o_out       (w_sum)
    );

    assign w_exact = {1'b0, w_in1} + {1'b0, w_in2};
    assign w_fire  = r_full && i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full    <= 1'b0;
            r_ptr     <= '0;
            r_id      <= '0;
            r_sum     <= '0;
            r_exact   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_fire && r_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (w_accept) begin
                r_full  <= 1'b1;
                r_id    <= w_grant;
                r_sum   <= w_sum;
                r_exact <= w_exact;
                r_err   <= (w_sum != w_exact);
                r_ptr   <= wrap_add(w_grant, 1);
            end else if (w_fire) begin
                r_full  <= 1'b0;
            end
        end
    end

    assign o_req_ready = w_ready;
    assign o_rsp_valid = r_full;
    assign o_rsp_id    = r_id;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_exact = r_exact;
    assign o_rsp_err   = r_err;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_approx_add_rr_sched.sv
// Directed plus randomized bench for approx_add_rr_sched against a transaction-level model.
module tb_approx_add_rr_sched;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          approx_en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [W:0]    rsp_sum;
    logic [W:0]    rsp_exact;
    logic          rsp_err;
    logic [15:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    bit          m_full;
    int          m_ptr;
    int          m_id;
    int          m_sum;
    int          m_exact;
    bit          m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    approx_add_rr_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_approx_en (approx_en),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_in1   (req_in1),
        .i_req_in2   (req_in2),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_exact (rsp_exact),
        .o_rsp_err   (rsp_err),
        .o_err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Approximate low part bit by bit, upper part as plain integer addition.
    function automatic int model_sum(input int a, input int b, input bit en);
        int z, low, s, x, y;
        if (!en || AB == 0) return a + b;
        z   = 0;
        low = 0;
        for (int i = 0; i < AB; i++) begin
            x = (a >> i) & 1;
            y = (b >> i) & 1;
            s = ((1 - x) & y) | (x & (1 - z));
            low = low | (s << i);
            z = x | (1 - z);
        end
        return ((((a >> AB) + (b >> AB) + z)) << AB) | low;
    endfunction

    task automatic cycle();
        int g, a, b, p;
        logic [3:0] exp_rdy;
        bit fire;
        #2;
        g = -1;
        if (!rst && (!m_full || rsp_ready))
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (g < 0 && req_valid[p]) g = p;
            end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            m_full = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_exact = 0; m_err = 0; m_cnt = 0;
        end else begin
            fire = m_full && rsp_ready;
            if (fire && m_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (g >= 0) begin
                a       = int'(req_in1[g*W +: W]);
                b       = int'(req_in2[g*W +: W]);
                m_sum   = model_sum(a, b, approx_en);
                m_exact = a + b;
                m_err   = (m_sum != m_exact);
                m_id    = g;
                m_full  = 1;
                m_ptr   = (g + 1) % N;
            end else if (fire) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (m_full) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
            chk("rsp_exact", 32'(rsp_exact), 32'(m_exact));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    endtask

    task automatic set_ops(input int r, input int a, input int b);
        req_in1[r*W +: W] = W'(a);
        req_in2[r*W +: W] = W'(b);
    endtask

    initial begin
        int exp_ids[5];
        m_full = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_exact = 0; m_err = 0; m_cnt = 0;
        rst = 1; approx_en = 0; req_valid = '0; rsp_ready = 0;
        req_in1 = '0; req_in2 = '0;
        @(posedge clk); #1;
        repeat (3) cycle();
        rst = 0;

        // idle after reset
        repeat (10) cycle();
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_id", 32'(rsp_id), 32'd0);
        chk("idle_sum", 32'(rsp_sum), 32'd0);
        chk("idle_exact", 32'(rsp_exact), 32'd0);
        chk("idle_err", 32'(rsp_err), 32'd0);
        chk("idle_cnt", 32'(err_cnt), 32'd0);

        // requester 0 alone, approximate
        rsp_ready = 1; approx_en = 1;
        set_ops(0, 8'h03, 8'h00);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        chk("t2_id", 32'(rsp_id), 32'd0);
        chk("t2_sum", 32'(rsp_sum), 32'h005);
        chk("t2_exact", 32'(rsp_exact), 32'h003);
        chk("t2_err", 32'(rsp_err), 32'd1);
        cycle();
        chk("t2_cnt", 32'(err_cnt), 32'd1);

        // requester 1, carry out of the top cell
        set_ops(1, 8'hFF, 8'h01);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        chk("t3_sum_apx", 32'(rsp_sum), 32'h101);
        chk("t3_exact", 32'(rsp_exact), 32'h100);
        chk("t3_err_apx", 32'(rsp_err), 32'd1);
        cycle();
        approx_en = 0;
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        chk("t3_sum_exa", 32'(rsp_sum), 32'h100);
        chk("t3_err_exa", 32'(rsp_err), 32'd0);
        cycle();

        // all requesters valid from ptr 0
        rst = 1; cycle(); rst = 0;
        approx_en = 1;
        for (int r = 0; r < N; r++) set_ops(r, $urandom_range(0, 255), $urandom_range(0, 255));
        req_valid = 4'b1111;
        exp_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_order", 32'(rsp_id), 32'(exp_ids[i]));
        end

        // back-pressure then release
        rsp_ready = 0;
        repeat (5) begin
            cycle();
            chk("t5_held_id", 32'(rsp_id), 32'd0);
        end
        rsp_ready = 1;
        cycle();
        chk("t5_next_id", 32'(rsp_id), 32'd1);

        // counter saturation
        for (int r = 0; r < N; r++) set_ops(r, 8'h03, 8'h00);
        force dut.r_err_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1;
        release dut.r_err_cnt;
        repeat (5) cycle();
        chk("t6_sat", 32'(err_cnt), 32'hFFFF);

        // reset in the middle of a held response
        rsp_ready = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1;
        cycle();
        chk("t6_rst_ptr", 32'(rsp_id), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            approx_en = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = 4'($urandom_range(0, 15));
            for (int r = 0; r < N; r++) set_ops(r, $urandom_range(0, 255), $urandom_range(0, 255));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
